vout_sample_logger: RTL and testbench

Downstream consumer of the buck converter simulator's output voltage. Takes the Q16.16 output-voltage sample (16-bit integer part + 16-bit decimal part) produced each simulation step and decimates it by 2**DECIM_LOG2. Buffers the decimated samples in a FIFO and presents them on a valid/ready stream for a host or UART link. Reports FIFO fill level, overflow, and dropped-sample count for run diagnostics.

---
 rtl/vout_sample_logger.sv | 216 +++++++++++++++++++++
 tb/tb_vout_sample_logger.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vout_sample_logger.sv
// -----------------------------------------------------------------------------
// vout_sample_logger
//
// Purpose:
//   Logs the output voltage of the buck converter simulator. Each simulation
//   step delivers one signed Q16.16 sample {v_int_i, v_dec_i}. The block keeps
//   one word per decimation window of 2**DECIM_LOG2 samples and buffers the
//   kept words in a DEPTH-entry FIFO. The FIFO head is presented on a
//   valid/ready stream for a host or UART link. The block also reports the
//   fill level, a sticky overflow flag and a saturating count of dropped words.
//
// Build option:
//   VOUT_LOGGER_AVG_EN - when defined, the kept word is the window average:
//                        the signed sum arithmetically shifted right by
//                        DECIM_LOG2, so it rounds toward -inf. When undefined,
//                        the kept word is the last sample of the window (pick
//                        mode) and no accumulator exists. Push timing is the
//                        same in both builds.
//
// Parameters:
//   DECIM_LOG2  decimation factor is 2**DECIM_LOG2 (0..8; 0 keeps every sample)
//   DEPTH       FIFO depth in 32-bit words (power of 2, >= 2)
//   AW          FIFO address width, log2(DEPTH)
//
// Ports:
//   clk_i       system clock; all logic updates on the rising edge
//   rst_n_i     asynchronous active-low reset
//   clr_i       synchronous clear of FIFO, decimator, accumulator, flags and
//               counters; takes priority over push and pop
//   smp_vld_i   one-cycle strobe: v_int_i / v_dec_i hold a new sample
//   v_int_i     voltage integer part, two's complement
//   v_dec_i     voltage fractional part, unsigned /65536
//   dat_o       head-of-FIFO word {int[15:0], dec[15:0]}; 0 while empty
//   vld_o       dat_o valid
//   rdy_i       consumer ready
//   level_o     number of words stored, 0..DEPTH
//   ovf_o       sticky: a kept word was dropped because the FIFO was full
//   drop_cnt_o  number of dropped words, saturates at 16'hFFFF
//
// Handshake (valid/ready):
//   A word transfers on a rising edge where vld_o && rdy_i. vld_o and dat_o
//   depend only on registers, so rdy_i has no combinational path to them.
//   Once vld_o is high, dat_o holds the same word until it is accepted.
//   vld_o falls the cycle after the last word is popped unless a push
//   happened in that same cycle.
// -----------------------------------------------------------------------------
module vout_sample_logger #(
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          smp_vld_i,
  input  logic [15:0]   v_int_i,
  input  logic [15:0]   v_dec_i,
  output logic [31:0]   dat_o,
  output logic          vld_o,
  input  logic          rdy_i,
  output logic [AW:0]   level_o,
  output logic          ovf_o,
  output logic [15:0]   drop_cnt_o
);

  // ---------------------------------------------------------------------------
  // Decimator
  // ---------------------------------------------------------------------------
  // The counter is 9 bits wide, which covers the largest window of 256
  // samples. A window of one sample (DECIM_LOG2 = 0) keeps the counter at 0,
  // so every valid sample closes a window.
  localparam int         WIN      = 1 << DECIM_LOG2;
  localparam logic [8:0] CNT_LAST = 9'(WIN - 1);

  logic [8:0]  dec_cnt;
  logic        win_last;
  logic [31:0] smp_word;
  logic [31:0] push_word;
  logic        push_req;

  assign smp_word = {v_int_i, v_dec_i};
  assign win_last = smp_vld_i && (dec_cnt == CNT_LAST);

  // A sample arriving during a clear is discarded, so no push can be
  // raised in that cycle.
  assign push_req = win_last && !clr_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dec_cnt <= '0;
    end else if (clr_i) begin
      dec_cnt <= '0;
    end else if (smp_vld_i) begin
      dec_cnt <= win_last ? 9'd0 : dec_cnt + 9'd1;
    end
  end

`ifdef VOUT_LOGGER_AVG_EN
  // ---------------------------------------------------------------------------
  // Window accumulator (average mode)
  // ---------------------------------------------------------------------------
  // The accumulator has DECIM_LOG2 guard bits, so the sum of a full window
  // of signed samples cannot overflow. acc_sum includes the current sample,
  // so the closing sample is part of the average pushed in that same cycle.
  localparam int ACC_W = 32 + DECIM_LOG2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_avg;

  assign acc_sum   = acc_q + ACC_W'($signed(smp_word));
  assign acc_avg   = acc_sum >>> DECIM_LOG2;
  assign push_word = acc_avg[31:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (smp_vld_i) begin
      acc_q <= win_last ? '0 : acc_sum;
    end
  end
`else
  // Pick mode: the last sample of the window is the kept word.
  assign push_word = smp_word;
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Full and empty are derived from the level counter, so both pointers can
  // wrap freely modulo DEPTH.
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          push_drop;

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);
  assign pop   = !empty && rdy_i;

  // When the FIFO is full and a pop happens in the same cycle, the pop frees
  // the head slot at this edge. That slot is the one wr_ptr points to, so the
  // new word becomes the newest entry and the level does not change.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;

  // The storage array has no reset. Stale contents are never observed,
  // because dat_o is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push_ok) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Diagnostics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (push_drop) begin
      ovf_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stream outputs
  // ---------------------------------------------------------------------------
  // These outputs decode only registered state. A word written at an edge
  // into an empty FIFO therefore appears one cycle later, and there is no
  // same-cycle fall-through.
  assign vld_o   = !empty;
  assign dat_o   = empty ? 32'd0 : mem[rd_ptr];
  assign level_o = level;

endmodule

// File: tb/tb_vout_sample_logger.sv
// -----------------------------------------------------------------------------
// tb_vout_sample_logger
//
// Self-checking bench for vout_sample_logger, using DECIM_LOG2 = 2 and
// DEPTH = 16.
//
// The reference model runs on the rising edge and describes the design by its
// rules only:
//   - samples are collected into a window queue;
//   - a full window yields one word (the last sample, or the floor average
//     when VOUT_LOGGER_AVG_EN is defined);
//   - the word enters a bounded FIFO whose occupancy is a plain integer.
// Each accepted word is pushed onto exp_q.
//
// A separate monitor on the falling edge compares the status outputs with the
// model. Whenever the design presents a word, the monitor checks it against
// the head of exp_q, and pops exp_q when the word transfers.
// -----------------------------------------------------------------------------
module tb_vout_sample_logger;

  localparam int DECIM_LOG2 = 2;
  localparam int DEPTH      = 16;
  localparam int AW         = 4;
  localparam int WIN        = 1 << DECIM_LOG2;

  // ---------------------------------------------------------------------------
  // Clock, reset and design under test
  // ---------------------------------------------------------------------------
  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clr     = 1'b0;
  logic        smp_vld = 1'b0;
  logic [15:0] v_int   = '0;
  logic [15:0] v_dec   = '0;
  logic        rdy     = 1'b0;

  logic [31:0] dat;
  logic        vld;
  logic [AW:0] level;
  logic        ovf;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  vout_sample_logger #(
    .DECIM_LOG2 (DECIM_LOG2),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clr_i      (clr),
    .smp_vld_i  (smp_vld),
    .v_int_i    (v_int),
    .v_dec_i    (v_dec),
    .dat_o      (dat),
    .vld_o      (vld),
    .rdy_i      (rdy),
    .level_o    (level),
    .ovf_o      (ovf),
    .drop_cnt_o (drop_cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] win_q[$];
  int          m_level = 0;
  bit          m_ovf   = 1'b0;
  int          m_drops = 0;
  int          n_vec   = 0;
  int          n_fail  = 0;

  // Word produced by one complete window of samples.
  function automatic logic [31:0] window_word();
`ifdef VOUT_LOGGER_AVG_EN
    longint sum;
    sum = 0;
    foreach (win_q[i]) sum += longint'($signed(win_q[i]));
    // longint is signed, so >>> rounds toward -inf.
    return 32'(sum >>> DECIM_LOG2);
`else
    return win_q[WIN-1];
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n || clr) begin
      win_q.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      bit          pop_m;
      bit          push_m;
      logic [31:0] w;
      pop_m  = (m_level > 0) && rdy;
      push_m = 1'b0;
      w      = '0;
      if (smp_vld) begin
        win_q.push_back({v_int, v_dec});
        if (win_q.size() == WIN) begin
          w      = window_word();
          push_m = 1'b1;
          win_q.delete();
        end
      end
      if (push_m) begin
        if (m_level < DEPTH || pop_m) begin
          exp_q.push_back(w);
          m_level++;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (pop_m) m_level--;
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", 32'(level), 32'(m_level));
      check("vld", 32'(vld), 32'(m_level > 0));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
      if (vld) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL dat_unexpected: got 0x%08h, expected no word at %0t", dat, $time);
        end else begin
          check("dat", dat, exp_q[0]);
          // A clear in this cycle wins over the pop, so the word does not transfer.
          if (rdy && !clr) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Inputs change 1 ns after the rising edge, so they are stable at the edge
  // where they take effect.
  task automatic drive(input bit v, input logic [31:0] s, input bit r, input bit c);
    @(posedge clk);
    #1;
    smp_vld = v;
    {v_int, v_dec} = s;
    rdy = r;
    clr = c;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && m_level > 0; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dat", dat, 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Eight ramp samples give two decimated words
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i) << 16, 1'b1, 1'b0);
    repeat (10) drive(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("ramp_level_idle", 32'(level), 32'd0);

    // Overflow: 80 samples give 20 words; 4 of them are dropped
    for (int i = 0; i < 80; i++) drive(1'b1, 32'h0100_0000 + 32'(i), 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd4);

    // While full, a push and a pop in the same cycle keep the level and the word
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hABCD_0000 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hABCD_0003, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_pp_level", 32'(level), 32'd16);
    check("full_pp_drops", 32'(drop_cnt), 32'd4);
    drain();

    // rdy toggling every cycle while words are valid
    for (int i = 0; i < 120; i++) drive(1'($urandom_range(0, 1)), $urandom, 1'(i % 2), 1'b0);
    drain();

    // Clear with level 5 and a partial window
    for (int i = 0; i < 22; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_level", 32'(level), 32'd0);
    check("clr_vld", 32'(vld), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_partial_level", 32'(level), 32'd0);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_window_level", 32'(level), 32'd1);
    drain();

    // Random traffic; each segment uses a different ready density
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 95);
      for (int i = 0; i < 100; i++) begin
        drive(1'($urandom_range(0, 3) != 0), $urandom,
              1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 79) == 0));
      end
    end
    drain();

    // Signed window: pick mode yields 0xFFFF0000, average mode yields 0x00014000
    drive(1'b1, 32'h0001_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h0002_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h0003_0000, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFF_0000, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drain();

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Time limit for the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
